// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt aggregator for the PicoRV32 irq vector.
// Each source is captured as a rising edge or as a level into PENDING. Captures
// are gated by ENABLE onto cpu_irq[IRQ_BASE +: NUM_SRC]. OVERRUN records edges
// that arrive while already pending. COUNT tallies cycles with new edge captures.
module irq_controller #(
    parameter int NUM_SRC  = 8,
    parameter int IRQ_BASE = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               mem_valid,
    input  logic [3:0]         mem_wstrb,
    input  logic [4:0]         mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata,
    output logic [31:0]        cpu_irq
);

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_EDGE_SEL = 3'd2;
    localparam logic [2:0] REG_RAW      = 3'd3;
    localparam logic [2:0] REG_OVERRUN  = 3'd4;
    localparam logic [2:0] REG_COUNT    = 3'd5;

    localparam int PAD = 32 - NUM_SRC;

    // Architectural state
    logic [NUM_SRC-1:0] prev_reg;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] edge_sel_reg;
    logic [NUM_SRC-1:0] overrun_reg;
    logic [31:0]        count_reg;
    logic               mem_ready_reg;
    logic [31:0]        mem_rdata_reg;
    logic [31:0]        cpu_irq_reg;

    // Next-state values
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] enable_next;
    logic [NUM_SRC-1:0] edge_sel_next;
    logic [NUM_SRC-1:0] overrun_next;
    logic [31:0]        count_next;
    logic [31:0]        rdata_next;
    logic [31:0]        cpu_irq_next;

    // Bus decode
    logic               access;
    logic               wr_en;
    logic [2:0]         reg_sel;
    logic               wr_pending;
    logic               wr_enable;
    logic               wr_edge_sel;
    logic               wr_overrun;
    logic               wr_count;
    logic [31:0]        byte_mask;

    // Per-source capture terms
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] w1c_bits;
    logic [NUM_SRC-1:0] new_capture;
    logic               any_capture;

    // mem_ready is high for the cycle after acceptance, while the CPU still
    // holds mem_valid; masking with mem_ready_reg stops a double accept.
    assign access      = mem_valid & ~mem_ready_reg;
    assign wr_en       = access & (|mem_wstrb);
    assign reg_sel     = mem_addr[4:2];
    assign wr_pending  = wr_en & (reg_sel == REG_PENDING);
    assign wr_enable   = wr_en & (reg_sel == REG_ENABLE);
    assign wr_edge_sel = wr_en & (reg_sel == REG_EDGE_SEL);
    assign wr_overrun  = wr_en & (reg_sel == REG_OVERRUN);
    assign wr_count    = wr_en & (reg_sel == REG_COUNT);
    assign byte_mask   = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                          {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign rise[gi]     = src_irq[gi] & ~prev_reg[gi];
            assign w1c_bits[gi] = mem_wdata[gi] & byte_mask[gi];

            // Edge mode: a rise beats a same-cycle clear. Level mode: follow the line.
            assign pending_next[gi] = edge_sel_reg[gi]
                                    ? (rise[gi] | (pending_reg[gi] & ~(wr_pending & w1c_bits[gi])))
                                    : src_irq[gi];

            // Only an edge landing on an already-pending bit is an overrun.
            assign overrun_next[gi] = (edge_sel_reg[gi] & rise[gi] & pending_reg[gi])
                                    | (overrun_reg[gi] & ~(wr_overrun & w1c_bits[gi]));

            assign new_capture[gi] = edge_sel_reg[gi] & pending_next[gi] & ~pending_reg[gi];

            assign enable_next[gi]   = (wr_enable & byte_mask[gi])   ? mem_wdata[gi] : enable_reg[gi];
            assign edge_sel_next[gi] = (wr_edge_sel & byte_mask[gi]) ? mem_wdata[gi] : edge_sel_reg[gi];
        end
    endgenerate

    assign any_capture = |new_capture;

    // A clear that coincides with a capture leaves the new capture counted.
    assign count_next = wr_count ? {31'd0, any_capture}
                                 : count_reg + {31'd0, any_capture};

    assign cpu_irq_next = {{PAD{1'b0}}, pending_reg & enable_reg} << IRQ_BASE;

    // Read mux, evaluated on the pre-write register state
    always_comb begin
        rdata_next = 32'd0;
        case (reg_sel)
            REG_PENDING:  rdata_next = {{PAD{1'b0}}, pending_reg};
            REG_ENABLE:   rdata_next = {{PAD{1'b0}}, enable_reg};
            REG_EDGE_SEL: rdata_next = {{PAD{1'b0}}, edge_sel_reg};
            REG_RAW:      rdata_next = {{PAD{1'b0}}, src_irq};
            REG_OVERRUN:  rdata_next = {{PAD{1'b0}}, overrun_reg};
            REG_COUNT:    rdata_next = count_reg;
            default:      rdata_next = 32'd0;
        endcase
    end

    // State update; EDGE_SEL comes out of reset as all-ones (edge capture)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_reg      <= '0;
            pending_reg   <= '0;
            enable_reg    <= '0;
            edge_sel_reg  <= '1;
            overrun_reg   <= '0;
            count_reg     <= 32'd0;
            mem_ready_reg <= 1'b0;
            mem_rdata_reg <= 32'd0;
            cpu_irq_reg   <= 32'd0;
        end else begin
            prev_reg      <= src_irq;
            pending_reg   <= pending_next;
            enable_reg    <= enable_next;
            edge_sel_reg  <= edge_sel_next;
            overrun_reg   <= overrun_next;
            count_reg     <= count_next;
            mem_ready_reg <= access;
            cpu_irq_reg   <= cpu_irq_next;
            if (access) begin
                mem_rdata_reg <= rdata_next;
            end
        end
    end

    assign mem_ready = mem_ready_reg;
    assign mem_rdata = mem_rdata_reg;
    assign cpu_irq   = cpu_irq_reg;

    // Byte-offset bits and data/strobe lanes above NUM_SRC carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata, byte_mask};

endmodule
